decode_issue_stage: RTL and testbench

Parametrised decode/issue stage: accepts a fetched instruction over a valid/ready handshake, decodes the RV32I format, reads the internal register file, generates the sign-extended immediate and holds the result in an output register toward execute. A per-register scoreboard tracks destinations in flight and stalls on RAW/WAW hazards. Writeback arrives on `WB_PORTS` independent ports. A flush from execute kills the younger instruction held here.

---
 rtl/decode_issue_stage.sv | 336 +++++++++++++++++++++++++++++++++
 tb/tb_decode_issue_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_stage.sv
// -----------------------------------------------------------------------------
// decode_issue_stage
//
// Purpose:
//   RV32I decode/issue stage. Takes one fetched instruction per cycle over a
//   valid/ready handshake, decodes it, reads operands from the internal
//   register file, builds the sign-extended immediate and holds the result in
//   an output register toward execute. A per-register scoreboard tracks
//   destinations in flight and stalls on RAW/WAW hazards. Writebacks arrive
//   on WB_PORTS independent ports. A flush kills the held instruction.
//
// Configuration macro:
//   DECODE_WB_BYPASS_EN - when defined, a writeback in cycle N is visible to
//   operand reads and to the hazard check in the same cycle N. When not
//   defined, reads and hazard see only the flopped register file/scoreboard.
//
// Ports:
//   clk, rst             clock; synchronous active-low reset
//   in_valid/in_ready    fetch handshake
//   in_instr, in_pc      instruction word and its PC
//   flush                execute redirect, kills held and incoming instr
//   out_valid/out_ready  execute handshake
//   out_pc, out_rs1_data, out_rs2_data, out_imm   decoded operands
//   out_opcode, out_funct3, out_funct7b5          control fields
//   out_rd, out_rd_we    destination and write enable
//   out_illegal          unsupported opcode
//   wb_valid, wb_addr, wb_data  writeback ports (flattened, port p at slice p)
//   o_dbg_pending        scoreboard state, exposed for observation
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both 1. A producer holding valid=1 keeps its payload
// stable until the transfer. ready may depend combinationally on valid.
// -----------------------------------------------------------------------------
module decode_issue_stage #(
   parameter  int XLEN       = 32,
   parameter  int REG_COUNT  = 32,
   parameter  int WB_PORTS   = 2,
   localparam int REG_ADDR_W = $clog2(REG_COUNT)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [XLEN-1:0]                in_instr,
   input  logic [XLEN-1:0]                in_pc,
   input  logic                           flush,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [XLEN-1:0]                out_pc,
   output logic [XLEN-1:0]                out_rs1_data,
   output logic [XLEN-1:0]                out_rs2_data,
   output logic [XLEN-1:0]                out_imm,
   output logic [6:0]                     out_opcode,
   output logic [2:0]                     out_funct3,
   output logic                           out_funct7b5,
   output logic [REG_ADDR_W-1:0]          out_rd,
   output logic                           out_rd_we,
   output logic                           out_illegal,
   input  logic [WB_PORTS-1:0]            wb_valid,
   input  logic [WB_PORTS*REG_ADDR_W-1:0] wb_addr,
   input  logic [WB_PORTS*XLEN-1:0]       wb_data,
   output logic [REG_COUNT-1:0]           o_dbg_pending
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [XLEN-1:0]       r_regs [REG_COUNT];
   logic [REG_COUNT-1:0]  r_pending;

   logic                  r_out_valid;
   logic [XLEN-1:0]       r_out_pc;
   logic [XLEN-1:0]       r_out_rs1_data;
   logic [XLEN-1:0]       r_out_rs2_data;
   logic [XLEN-1:0]       r_out_imm;
   logic [6:0]            r_out_opcode;
   logic [2:0]            r_out_funct3;
   logic                  r_out_funct7b5;
   logic [REG_ADDR_W-1:0] r_out_rd;
   logic                  r_out_rd_we;
   logic                  r_out_illegal;

   // ---------------------------------------------------------------------------
   // Field extraction
   // ---------------------------------------------------------------------------
   logic [31:0]           w_i;
   logic [6:0]            w_opcode;
   logic [2:0]            w_funct3;
   logic                  w_funct7b5;
   logic [REG_ADDR_W-1:0] w_rd;
   logic [REG_ADDR_W-1:0] w_rs1;
   logic [REG_ADDR_W-1:0] w_rs2;

   assign w_i        = in_instr[31:0];
   assign w_opcode   = w_i[6:0];
   assign w_funct3   = w_i[14:12];
   assign w_funct7b5 = w_i[30];
   assign w_rd       = w_i[7  +: REG_ADDR_W];
   assign w_rs1      = w_i[15 +: REG_ADDR_W];
   assign w_rs2      = w_i[20 +: REG_ADDR_W];

   // ---------------------------------------------------------------------------
   // Decode: operand usage, destination enable and 32-bit immediate
   // ---------------------------------------------------------------------------
   logic        w_rs1_use;
   logic        w_rs2_use;
   logic        w_rd_we_raw;
   logic        w_rd_we;
   logic        w_illegal;
   logic [31:0] w_imm32;
   logic [XLEN-1:0] w_imm;

   always_comb begin
      w_rs1_use   = 1'b0;
      w_rs2_use   = 1'b0;
      w_rd_we_raw = 1'b0;
      w_illegal   = 1'b0;
      w_imm32     = 32'd0;
      case (w_opcode)
         OPC_LUI, OPC_AUIPC: begin
            w_rd_we_raw = 1'b1;
            w_imm32     = {w_i[31:12], 12'd0};
         end
         OPC_JAL: begin
            w_rd_we_raw = 1'b1;
            w_imm32     = {{11{w_i[31]}}, w_i[31], w_i[19:12], w_i[20],
                           w_i[30:21], 1'b0};
         end
         OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
            w_rs1_use   = 1'b1;
            w_rd_we_raw = 1'b1;
            w_imm32     = {{20{w_i[31]}}, w_i[31:20]};
         end
         OPC_BRANCH: begin
            w_rs1_use = 1'b1;
            w_rs2_use = 1'b1;
            w_imm32   = {{19{w_i[31]}}, w_i[31], w_i[7], w_i[30:25],
                         w_i[11:8], 1'b0};
         end
         OPC_STORE: begin
            w_rs1_use = 1'b1;
            w_rs2_use = 1'b1;
            w_imm32   = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
         end
         OPC_OP: begin
            w_rs1_use   = 1'b1;
            w_rs2_use   = 1'b1;
            w_rd_we_raw = 1'b1;
         end
         default: begin
            w_illegal = 1'b1;
         end
      endcase
   end

   // x0 is never a real destination, so it never enters the scoreboard
   assign w_rd_we = w_rd_we_raw && (w_rd != '0);

   // Replicated sign bit count is always >= 1, so this also covers XLEN == 32
   assign w_imm = {{(XLEN-31){w_imm32[31]}}, w_imm32[30:0]};

   // ---------------------------------------------------------------------------
   // Writeback decode: clear mask for the scoreboard
   // ---------------------------------------------------------------------------
   logic [REG_COUNT-1:0] w_wb_clr;

   always_comb begin
      w_wb_clr = '0;
      for (int p = 0; p < WB_PORTS; p++) begin
         if (wb_valid[p]) begin
            w_wb_clr[wb_addr[p*REG_ADDR_W +: REG_ADDR_W]] = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Operand read
   // ---------------------------------------------------------------------------
   logic [XLEN-1:0] w_rs1_data;
   logic [XLEN-1:0] w_rs2_data;

   always_comb begin
      w_rs1_data = (w_rs1 == '0) ? '0 : r_regs[w_rs1];
      w_rs2_data = (w_rs2 == '0) ? '0 : r_regs[w_rs2];
`ifdef DECODE_WB_BYPASS_EN
      // Ascending loop: the highest matching port overrides lower ones
      for (int p = 0; p < WB_PORTS; p++) begin
         if (wb_valid[p] && (w_rs1 != '0) &&
             (wb_addr[p*REG_ADDR_W +: REG_ADDR_W] == w_rs1)) begin
            w_rs1_data = wb_data[p*XLEN +: XLEN];
         end
         if (wb_valid[p] && (w_rs2 != '0) &&
             (wb_addr[p*REG_ADDR_W +: REG_ADDR_W] == w_rs2)) begin
            w_rs2_data = wb_data[p*XLEN +: XLEN];
         end
      end
`endif
   end

   // ---------------------------------------------------------------------------
   // Hazard detection
   // ---------------------------------------------------------------------------
   logic [REG_COUNT-1:0] w_pend_view;
   logic [REG_COUNT-1:0] w_held_mask;
   logic [REG_COUNT-1:0] w_busy;
   logic                 w_hazard;
   logic                 w_accept;
   logic                 w_issue;

`ifdef DECODE_WB_BYPASS_EN
   assign w_pend_view = r_pending & ~w_wb_clr;
`else
   assign w_pend_view = r_pending;
`endif

   // The instruction sitting in the output register has not yet set its
   // scoreboard bit, so its destination is added here.
   always_comb begin
      w_held_mask = '0;
      if (r_out_valid && r_out_rd_we) begin
         w_held_mask[r_out_rd] = 1'b1;
      end
   end

   assign w_busy   = w_pend_view | w_held_mask;
   assign w_hazard = in_valid && ((w_rs1_use && w_busy[w_rs1]) ||
                                  (w_rs2_use && w_busy[w_rs2]) ||
                                  (w_rd_we   && w_busy[w_rd]));

   assign in_ready = rst && (!r_out_valid || out_ready) && !w_hazard && !flush;
   assign w_accept = in_valid && in_ready;

   // A flushed instruction never reaches execute, so it must not mark its
   // destination as in flight.
   assign w_issue  = r_out_valid && out_ready && r_out_rd_we && !flush;

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   logic [REG_COUNT-1:0] w_set_mask;
   logic [REG_COUNT-1:0] w_pending_nxt;

   always_comb begin
      w_set_mask = '0;
      if (w_issue) begin
         w_set_mask[r_out_rd] = 1'b1;
      end
      // Set is OR-ed after the clear so it wins on the same bit
      w_pending_nxt    = (r_pending & ~w_wb_clr) | w_set_mask;
      w_pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pending <= '0;
      end else begin
         r_pending <= w_pending_nxt;
      end
   end

   assign o_dbg_pending = r_pending;

   // ---------------------------------------------------------------------------
   // Register file: ascending port loop makes the highest port win
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int r = 0; r < REG_COUNT; r++) begin
            r_regs[r] <= '0;
         end
      end else begin
         for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_valid[p] && (wb_addr[p*REG_ADDR_W +: REG_ADDR_W] != '0)) begin
               r_regs[wb_addr[p*REG_ADDR_W +: REG_ADDR_W]] <= wb_data[p*XLEN +: XLEN];
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Output register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_out_valid    <= 1'b0;
         r_out_pc       <= '0;
         r_out_rs1_data <= '0;
         r_out_rs2_data <= '0;
         r_out_imm      <= '0;
         r_out_opcode   <= '0;
         r_out_funct3   <= '0;
         r_out_funct7b5 <= 1'b0;
         r_out_rd       <= '0;
         r_out_rd_we    <= 1'b0;
         r_out_illegal  <= 1'b0;
      end else if (w_accept) begin
         r_out_valid    <= 1'b1;
         r_out_pc       <= in_pc;
         r_out_rs1_data <= w_rs1_data;
         r_out_rs2_data <= w_rs2_data;
         r_out_imm      <= w_imm;
         r_out_opcode   <= w_opcode;
         r_out_funct3   <= w_funct3;
         r_out_funct7b5 <= w_funct7b5;
         r_out_rd       <= w_rd;
         r_out_rd_we    <= w_rd_we;
         r_out_illegal  <= w_illegal;
      end else if (flush || out_ready) begin
         // Drain or kill: only valid drops, payload holds its last value
         r_out_valid    <= 1'b0;
      end
   end

   assign out_valid    = r_out_valid;
   assign out_pc       = r_out_pc;
   assign out_rs1_data = r_out_rs1_data;
   assign out_rs2_data = r_out_rs2_data;
   assign out_imm      = r_out_imm;
   assign out_opcode   = r_out_opcode;
   assign out_funct3   = r_out_funct3;
   assign out_funct7b5 = r_out_funct7b5;
   assign out_rd       = r_out_rd;
   assign out_rd_we    = r_out_rd_we;
   assign out_illegal  = r_out_illegal;

endmodule

// File: tb/tb_decode_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_issue_stage
//
// Purpose:
//   Directed self-checking bench for decode_issue_stage with hand-computed
//   expected values. Inputs are driven 1 time unit after the rising edge and
//   outputs are sampled before the next rising edge.
// -----------------------------------------------------------------------------
module tb_decode_issue_stage;

   localparam int XLEN = 32;
   localparam int RC   = 32;
   localparam int AW   = 5;
   localparam int WBP  = 2;

`ifdef DECODE_WB_BYPASS_EN
   localparam int EXP_STALL = 2;
`else
   localparam int EXP_STALL = 3;
`endif

   localparam logic [31:0] I_ADDI_X1 = 32'h00500093; // addi x1,x0,5
   localparam logic [31:0] I_ADD_X2  = 32'h00108133; // add  x2,x1,x1
   localparam logic [31:0] I_ADD_X4  = 32'h00018233; // add  x4,x3,x0
   localparam logic [31:0] I_ADD_X5  = 32'h002002B3; // add  x5,x0,x2
   localparam logic [31:0] I_SW      = 32'hFE20AE23; // sw   x2,-4(x1)
   localparam logic [31:0] I_ADDI_X6 = 32'h00100313; // addi x6,x0,1
   localparam logic [31:0] I_ADDI_X7 = 32'h00200393; // addi x7,x0,2
   localparam logic [31:0] I_ADD_X10 = 32'h00020533; // add  x10,x4,x0

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid;
   logic                 in_ready;
   logic [XLEN-1:0]      in_instr;
   logic [XLEN-1:0]      in_pc;
   logic                 flush;
   logic                 out_valid;
   logic                 out_ready;
   logic [XLEN-1:0]      out_pc;
   logic [XLEN-1:0]      out_rs1_data;
   logic [XLEN-1:0]      out_rs2_data;
   logic [XLEN-1:0]      out_imm;
   logic [6:0]           out_opcode;
   logic [2:0]           out_funct3;
   logic                 out_funct7b5;
   logic [AW-1:0]        out_rd;
   logic                 out_rd_we;
   logic                 out_illegal;
   logic [WBP-1:0]       wb_valid;
   logic [WBP*AW-1:0]    wb_addr;
   logic [WBP*XLEN-1:0]  wb_data;
   logic [RC-1:0]        o_dbg_pending;

   always #5 clk = ~clk;

   decode_issue_stage #(
      .XLEN      (XLEN),
      .REG_COUNT (RC),
      .WB_PORTS  (WBP)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_instr      (in_instr),
      .in_pc         (in_pc),
      .flush         (flush),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_pc        (out_pc),
      .out_rs1_data  (out_rs1_data),
      .out_rs2_data  (out_rs2_data),
      .out_imm       (out_imm),
      .out_opcode    (out_opcode),
      .out_funct3    (out_funct3),
      .out_funct7b5  (out_funct7b5),
      .out_rd        (out_rd),
      .out_rd_we     (out_rd_we),
      .out_illegal   (out_illegal),
      .wb_valid      (wb_valid),
      .wb_addr       (wb_addr),
      .wb_data       (wb_data),
      .o_dbg_pending (o_dbg_pending)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard counters and expected queue
   // ---------------------------------------------------------------------------
   int n_vec = 0;
   int n_err = 0;
   logic [XLEN-1:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [63:0] act,
                           input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_in(input logic v, input logic [31:0] instr,
                           input logic [31:0] pc);
      in_valid = v;
      in_instr = instr;
      in_pc    = pc;
   endtask

   task automatic drive_wb(input logic [1:0] v, input logic [4:0] a0,
                           input logic [4:0] a1, input logic [31:0] d0,
                           input logic [31:0] d1);
      wb_valid = v;
      wb_addr  = {a1, a0};
      wb_data  = {d1, d0};
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   logic [31:0] seq_instr [3];
   logic [31:0] seq_imm   [3];
   logic        seq_we    [3];
   logic [4:0]  seq_rd    [3];
   int          stall;
   logic        got;
   logic [XLEN-1:0] exp_imm;

   initial begin
      rst       = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      drive_in(1'b0, 32'd0, 32'd0);
      drive_wb(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);

      // lui x8,0x12345 / beq x0,x0,-8 / jal x9,-4
      seq_instr[0] = 32'h12345437; seq_imm[0] = 32'h12345000; seq_we[0] = 1'b1; seq_rd[0] = 5'd8;
      seq_instr[1] = 32'hFE000CE3; seq_imm[1] = 32'hFFFFFFF8; seq_we[1] = 1'b0; seq_rd[1] = 5'd25;
      seq_instr[2] = 32'hFFDFF4EF; seq_imm[2] = 32'hFFFFFFFC; seq_we[2] = 1'b1; seq_rd[2] = 5'd9;

      // ---- reset ----
      tick;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_pending", o_dbg_pending, 0);
      check_eq("rst_out_pc", out_pc, 0);
      check_eq("rst_out_imm", out_imm, 0);
      check_eq("rst_out_rd_we", out_rd_we, 0);
      drive_in(1'b1, I_ADDI_X1, 32'h100);
      #1;
      check_eq("rst_in_ready", in_ready, 0);
      tick;
      check_eq("rst_no_accept", out_valid, 0);

      // ---- addi x1,x0,5 ----
      rst = 1'b1;
      #1;
      check_eq("addi_in_ready", in_ready, 1);
      tick;
      check_eq("addi_out_valid", out_valid, 1);
      check_eq("addi_out_rd", out_rd, 1);
      check_eq("addi_out_imm", out_imm, 5);
      check_eq("addi_rs1_data", out_rs1_data, 0);
      check_eq("addi_rd_we", out_rd_we, 1);
      check_eq("addi_out_pc", out_pc, 32'h100);
      check_eq("addi_opcode", out_opcode, 7'h13);

      // ---- add x2,x1,x1: RAW stall until WB of x1 in loop cycle 2 ----
      drive_in(1'b1, I_ADD_X2, 32'h104);
      stall = 0;
      got   = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         if (c == 2) drive_wb(2'b01, 5'd1, 5'd0, 32'd5, 32'd0);
         else        drive_wb(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
         #1;
         if (in_ready) got = 1'b1;
         else          stall++;
         tick;
      end
      drive_wb(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
      drive_in(1'b0, 32'd0, 32'd0);
      check_eq("raw_accepted", got, 1);
      check_eq("raw_stall_cycles", stall, EXP_STALL);
      check_eq("raw_out_valid", out_valid, 1);
      check_eq("raw_rs1_data", out_rs1_data, 5);
      check_eq("raw_rs2_data", out_rs2_data, 5);
      check_eq("raw_out_rd", out_rd, 2);
      check_eq("raw_out_imm", out_imm, 0);
      tick;
      check_eq("drain_out_valid", out_valid, 0);
      check_eq("pending_x2", o_dbg_pending, 32'h4);

      // ---- dual WB to x3, then write x0 and x2 ----
      drive_wb(2'b11, 5'd3, 5'd3, 32'hAAAA, 32'h5555);
      tick;
      drive_wb(2'b11, 5'd0, 5'd2, 32'hDEAD, 32'd7);
      tick;
      drive_wb(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
      check_eq("wb_pending_clear", o_dbg_pending, 0);
      drive_in(1'b1, I_ADD_X4, 32'h108);
      #1;
      check_eq("x4_in_ready", in_ready, 1);
      tick;
      check_eq("x3_port1_wins", out_rs1_data, 32'h5555);
      check_eq("x4_rs2_x0", out_rs2_data, 0);
      drive_in(1'b1, I_ADD_X5, 32'h10C);
      #1;
      check_eq("b2b_in_ready", in_ready, 1);
      tick;
      check_eq("x0_reads_zero", out_rs1_data, 0);
      check_eq("x2_read", out_rs2_data, 7);
      check_eq("x5_out_pc", out_pc, 32'h10C);

      // ---- sw x2,-4(x1) held by out_ready=0 ----
      drive_in(1'b1, I_SW, 32'h110);
      tick;
      check_eq("sw_out_pc", out_pc, 32'h110);
      out_ready = 1'b0;
      drive_in(1'b1, I_ADDI_X6, 32'h114);
      for (int c = 0; c < 3; c++) begin
         #1;
         check_eq("hold_in_ready", in_ready, 0);
         check_eq("hold_out_valid", out_valid, 1);
         check_eq("hold_out_pc", out_pc, 32'h110);
         check_eq("hold_out_imm", out_imm, 32'hFFFFFFFC);
         check_eq("hold_rs1_rs2", {out_rs1_data, out_rs2_data}, {32'd5, 32'd7});
         check_eq("hold_ctl", {out_opcode, out_funct3, out_rd_we}, {7'h23, 3'd2, 1'b0});
         tick;
      end
      out_ready = 1'b1;
      #1;
      check_eq("release_in_ready", in_ready, 1);
      tick;
      check_eq("x6_out_pc", out_pc, 32'h114);
      check_eq("x6_out_rd", out_rd, 6);
      check_eq("pending_x4_x5", o_dbg_pending, 32'h30);

      // ---- flush with out_valid=1 and in_valid=1 ----
      out_ready = 1'b0;
      drive_in(1'b1, I_ADDI_X7, 32'h118);
      flush = 1'b1;
      #1;
      check_eq("flush_in_ready", in_ready, 0);
      tick;
      flush = 1'b0;
      drive_in(1'b0, 32'd0, 32'd0);
      out_ready = 1'b1;
      check_eq("flush_out_valid", out_valid, 0);
      check_eq("flush_no_accept_pc", out_pc, 32'h114);
      check_eq("flush_pending", o_dbg_pending, 32'h30);

      // ---- illegal instruction ----
      drive_in(1'b1, 32'hFFFFFFFF, 32'h11C);
      tick;
      drive_in(1'b0, 32'd0, 32'd0);
      check_eq("ill_out_valid", out_valid, 1);
      check_eq("ill_flag", out_illegal, 1);
      check_eq("ill_rd_we", out_rd_we, 0);
      check_eq("ill_imm", out_imm, 0);
      tick;
      check_eq("ill_no_pending", o_dbg_pending, 32'h30);

      // ---- U/B/J immediates, back-to-back ----
      for (int k = 0; k < 3; k++) begin
         drive_in(1'b1, seq_instr[k], 32'h200 + 32'(k * 4));
         #1;
         check_eq("seq_in_ready", in_ready, 1);
         exp_q.push_back(seq_imm[k]);
         tick;
         exp_imm = exp_q.pop_front();
         check_eq("seq_out_imm", out_imm, exp_imm);
         check_eq("seq_rd_we", out_rd_we, seq_we[k]);
         check_eq("seq_out_rd", out_rd, seq_rd[k]);
      end
      drive_in(1'b0, 32'd0, 32'd0);
      tick;
      check_eq("seq_pending", o_dbg_pending, 32'h330);

      // ---- reset in the middle of a stall ----
      drive_in(1'b1, I_ADD_X10, 32'h300);
      #1;
      check_eq("stall_in_ready", in_ready, 0);
      rst = 1'b0;
      tick;
      rst = 1'b1;
      drive_in(1'b0, 32'd0, 32'd0);
      check_eq("mid_rst_out_valid", out_valid, 0);
      check_eq("mid_rst_pending", o_dbg_pending, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
